// File: rtl/drain_scheduler.sv
// Read-side scheduler for four packet queues: arbitrates one non-empty queue per service slot,
// presents its head on a valid/ready port, pops it on acceptance and counts transfers.
module drain_scheduler #(
    parameter int unsigned PERIOD = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             mode,
    input  logic [3:0]       buf_nonempty,
    input  logic [7:0]       head_data,
    input  logic             tx_ready,
    output logic             tx_valid,
    output logic [1:0]       tx_id,
    output logic [1:0]       tx_data,
    output logic [3:0]       pop,
    output logic             busy,
    output logic [CNT_W-1:0] sent_count
);

    localparam int unsigned TW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [TW-1:0] GapLoad = TW'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap
    } state_e;

    state_e           state_q, state_d;
    logic             tx_valid_q, tx_valid_d;
    logic [1:0]       tx_id_q, tx_id_d;
    logic [1:0]       tx_data_q, tx_data_d;
    logic [3:0]       pop_q, pop_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;

    logic [1:0] win_prio;
    logic [1:0] win_rr;
    logic [1:0] win;
    logic [1:0] rr_idx;
    logic       rr_found;

    // Both arbiters are always evaluated; mode only picks which result is used.
    always_comb begin
        win_prio = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (buf_nonempty[k]) begin
                win_prio = 2'(k);
            end
        end

        win_rr   = 2'd0;
        rr_found = 1'b0;
        rr_idx   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            rr_idx = rr_ptr_q + 2'(i);
            if (!rr_found && buf_nonempty[rr_idx]) begin
                win_rr   = rr_idx;
                rr_found = 1'b1;
            end
        end

        win = mode ? win_prio : win_rr;
    end

    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_id_d    = tx_id_q;
        tx_data_d  = tx_data_q;
        pop_d      = 4'b0000;
        count_d    = count_q;
        timer_d    = timer_q;
        rr_ptr_d   = rr_ptr_q;

        unique case (state_q)
            StIdle: begin
                if (enable && (buf_nonempty != 4'b0000)) begin
                    tx_id_d    = win;
                    tx_data_d  = head_data[{win, 1'b0} +: 2];
                    tx_valid_d = 1'b1;
                    state_d    = StSend;
                end
            end
            StSend: begin
                // enable and buf_nonempty are deliberately ignored: a started transfer completes.
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    pop_d      = 4'b0001 << tx_id_q;
                    if (count_q != CntMax) begin
                        count_d = count_q + 1'b1;
                    end
                    rr_ptr_d = tx_id_q;
                    timer_d  = GapLoad;
                    state_d  = StGap;
                end
            end
            StGap: begin
                if (timer_q == '0) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d    = StIdle;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tx_valid_q <= 1'b0;
            tx_id_q    <= 2'd0;
            tx_data_q  <= 2'd0;
            pop_q      <= 4'b0000;
            count_q    <= '0;
            timer_q    <= '0;
            rr_ptr_q   <= 2'd3;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_id_q    <= tx_id_d;
            tx_data_q  <= tx_data_d;
            pop_q      <= pop_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign tx_valid   = tx_valid_q;
    assign tx_id      = tx_id_q;
    assign tx_data    = tx_data_q;
    assign pop        = pop_q;
    assign busy       = (state_q != StIdle);
    assign sent_count = count_q;

endmodule

// File: tb/tb_drain_scheduler.sv
// Directed bench for drain_scheduler: cycle-by-cycle vector table plus a round-robin sweep
// that also watches a narrow-counter instance saturate.
module tb_drain_scheduler;

    logic       clk = 1'b0;
    logic       rst, enable, mode, tx_ready;
    logic [3:0] buf_nonempty;
    logic [7:0] head_data;

    logic       tx_valid, busy;
    logic [1:0] tx_id, tx_data;
    logic [3:0] pop;
    logic [7:0] sent_count;

    logic       s_tx_valid, s_busy;
    logic [1:0] s_tx_id, s_tx_data;
    logic [3:0] s_pop;
    logic [1:0] s_sent_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    drain_scheduler #(.PERIOD(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .buf_nonempty(buf_nonempty),
        .head_data(head_data), .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_id(tx_id),
        .tx_data(tx_data), .pop(pop), .busy(busy), .sent_count(sent_count)
    );

    drain_scheduler #(.PERIOD(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .buf_nonempty(buf_nonempty),
        .head_data(head_data), .tx_ready(tx_ready), .tx_valid(s_tx_valid), .tx_id(s_tx_id),
        .tx_data(s_tx_data), .pop(s_pop), .busy(s_busy), .sent_count(s_sent_count)
    );

    typedef struct {
        logic       r, en, m;
        logic [3:0] ne;
        logic [7:0] hd;
        logic       rdy;
        logic       v;
        logic [1:0] id, dt;
        logic [3:0] p;
        logic       b;
        logic [7:0] c;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic en, input logic m, input logic [3:0] ne,
                       input logic [7:0] hd, input logic rdy, input logic v,
                       input logic [1:0] id, input logic [1:0] dt, input logic [3:0] p,
                       input logic b, input logic [7:0] c);
        vec_t x;
        x.r = r; x.en = en; x.m = m; x.ne = ne; x.hd = hd; x.rdy = rdy;
        x.v = v; x.id = id; x.dt = dt; x.p = p; x.b = b; x.c = c;
        vq.push_back(x);
    endtask

    task automatic fail_line(input string name, input int got, input int want);
        fails++;
        $display("FAIL %s: got %0d, required %0d", name, got, want);
    endtask

    initial begin
        int npop;
        int last;
        logic [3:0] exp_pop;
        int exp_sat;

        rst = 1'b1; enable = 1'b0; mode = 1'b0; tx_ready = 1'b0;
        buf_nonempty = 4'b0000; head_data = 8'h00;

        // q1 head = 3, q3 head = 1 (8'h4C); E4 puts payload k in queue k.
        //   r  en m  ne       hd     rdy  v  id dt pop      b  cnt
        add(1, 0, 0, 4'b0000, 8'h00, 0,   0, 0, 0, 4'b0000, 0, 0);  // reset state
        add(0, 1, 1, 4'b1010, 8'h4C, 0,   1, 1, 3, 4'b0000, 1, 0);  // strict: q1 wins
        add(0, 1, 1, 4'b1010, 8'h4C, 0,   1, 1, 3, 4'b0000, 1, 0);  // backpressure x7
        add(0, 1, 1, 4'b1010, 8'h4C, 0,   1, 1, 3, 4'b0000, 1, 0);
        add(0, 1, 1, 4'b1010, 8'h00, 0,   1, 1, 3, 4'b0000, 1, 0);  // head changes, held
        add(0, 1, 1, 4'b1010, 8'h4C, 0,   1, 1, 3, 4'b0000, 1, 0);
        add(0, 1, 1, 4'b1010, 8'h4C, 0,   1, 1, 3, 4'b0000, 1, 0);
        add(0, 1, 1, 4'b1010, 8'h4C, 0,   1, 1, 3, 4'b0000, 1, 0);
        add(0, 1, 1, 4'b1010, 8'h4C, 0,   1, 1, 3, 4'b0000, 1, 0);
        add(0, 1, 1, 4'b1010, 8'h4C, 1,   0, 1, 3, 4'b0010, 1, 1);  // accept -> pop q1
        add(0, 1, 1, 4'b1010, 8'h4C, 1,   0, 1, 3, 4'b0000, 1, 1);  // gap
        add(0, 1, 1, 4'b1010, 8'h4C, 1,   0, 1, 3, 4'b0000, 1, 1);
        add(0, 1, 1, 4'b1010, 8'h4C, 1,   0, 1, 3, 4'b0000, 1, 1);
        add(0, 1, 1, 4'b1010, 8'h4C, 1,   0, 1, 3, 4'b0000, 0, 1);  // idle
        add(0, 1, 1, 4'b1010, 8'h4C, 1,   1, 1, 3, 4'b0000, 1, 1);  // q1 again
        add(0, 1, 1, 4'b1010, 8'h4C, 1,   0, 1, 3, 4'b0010, 1, 2);
        add(0, 1, 1, 4'b1000, 8'h4C, 1,   0, 1, 3, 4'b0000, 1, 2);  // q1 drained
        add(0, 1, 1, 4'b1000, 8'h4C, 1,   0, 1, 3, 4'b0000, 1, 2);
        add(0, 1, 1, 4'b1000, 8'h4C, 1,   0, 1, 3, 4'b0000, 1, 2);
        add(0, 1, 1, 4'b1000, 8'h4C, 0,   0, 1, 3, 4'b0000, 0, 2);
        add(0, 1, 1, 4'b1000, 8'h4C, 0,   1, 3, 1, 4'b0000, 1, 2);  // q3 served
        add(0, 1, 1, 4'b1000, 8'h4C, 1,   0, 3, 1, 4'b1000, 1, 3);
        add(0, 1, 1, 4'b0000, 8'h4C, 0,   0, 3, 1, 4'b0000, 1, 3);
        add(0, 1, 1, 4'b0000, 8'h4C, 0,   0, 3, 1, 4'b0000, 1, 3);
        add(0, 1, 1, 4'b0000, 8'h4C, 0,   0, 3, 1, 4'b0000, 1, 3);
        add(0, 1, 1, 4'b0000, 8'h4C, 0,   0, 3, 1, 4'b0000, 0, 3);
        add(0, 1, 0, 4'b0001, 8'h02, 0,   1, 0, 2, 4'b0000, 1, 3);  // rr after q3 -> q0
        add(0, 0, 0, 4'b0000, 8'h02, 0,   1, 0, 2, 4'b0000, 1, 3);  // enable/nonempty drop
        add(0, 0, 0, 4'b0000, 8'h02, 1,   0, 0, 2, 4'b0001, 1, 4);  // still completes
        add(0, 0, 0, 4'b0000, 8'h02, 1,   0, 0, 2, 4'b0000, 1, 4);
        add(0, 0, 0, 4'b0000, 8'h02, 1,   0, 0, 2, 4'b0000, 1, 4);
        add(0, 0, 0, 4'b0000, 8'h02, 1,   0, 0, 2, 4'b0000, 1, 4);
        add(0, 0, 0, 4'b0000, 8'h02, 1,   0, 0, 2, 4'b0000, 0, 4);
        add(0, 0, 0, 4'b0000, 8'h02, 1,   0, 0, 2, 4'b0000, 0, 4);  // stays idle
        add(0, 1, 0, 4'b0000, 8'h02, 1,   0, 0, 2, 4'b0000, 0, 4);
        add(0, 1, 0, 4'b1111, 8'hE4, 0,   1, 1, 1, 4'b0000, 1, 4);  // rr after q0 -> q1
        add(1, 1, 0, 4'b1111, 8'hE4, 1,   0, 0, 0, 4'b0000, 0, 0);  // reset beats accept
        add(0, 1, 0, 4'b1111, 8'hE4, 0,   1, 0, 0, 4'b0000, 1, 0);  // rr restarts at q0
        add(0, 1, 0, 4'b1111, 8'hE4, 1,   0, 0, 0, 4'b0001, 1, 1);
        add(0, 1, 0, 4'b1111, 8'hE4, 1,   0, 0, 0, 4'b0000, 1, 1);

        foreach (vq[i]) begin
            rst = vq[i].r; enable = vq[i].en; mode = vq[i].m;
            buf_nonempty = vq[i].ne; head_data = vq[i].hd; tx_ready = vq[i].rdy;
            @(posedge clk); #1;
            tests++;
            if (tx_valid !== vq[i].v || tx_id !== vq[i].id || tx_data !== vq[i].dt ||
                pop !== vq[i].p || busy !== vq[i].b || sent_count !== vq[i].c) begin
                fails++;
                $display("FAIL vec%0d: got v=%b id=%0d data=%0d pop=%b busy=%b cnt=%0d, required v=%b id=%0d data=%0d pop=%b busy=%b cnt=%0d",
                         i, tx_valid, tx_id, tx_data, pop, busy, sent_count,
                         vq[i].v, vq[i].id, vq[i].dt, vq[i].p, vq[i].b, vq[i].c);
            end
        end

        // Round-robin sweep: pops 0,1,2,3,0, six edges apart (one pop cycle plus five quiet).
        rst = 1'b1; tx_ready = 1'b0; enable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; enable = 1'b1; mode = 1'b0; buf_nonempty = 4'b1111;
        head_data = 8'hE4; tx_ready = 1'b1;
        npop = 0;
        last = 0;
        for (int cyc = 0; cyc < 60 && npop < 5; cyc++) begin
            @(posedge clk); #1;
            if (pop != 4'b0000) begin
                exp_pop = 4'b0001 << (npop % 4);
                tests++;
                if (pop !== exp_pop || tx_valid !== 1'b0 || tx_id !== 2'(npop % 4) ||
                    tx_data !== 2'(npop % 4)) begin
                    fails++;
                    $display("FAIL rr_pop%0d: got pop=%b valid=%b id=%0d data=%0d, required pop=%b valid=0 id=%0d data=%0d",
                             npop, pop, tx_valid, tx_id, tx_data, exp_pop, npop % 4, npop % 4);
                end
                exp_sat = (npop + 1 > 3) ? 3 : npop + 1;
                tests++;
                if (s_sent_count !== 2'(exp_sat)) fail_line("sat_count", int'(s_sent_count), exp_sat);
                if (npop > 0) begin
                    tests++;
                    if (cyc - last != 6) fail_line("rr_spacing", cyc - last, 6);
                end
                last = cyc;
                npop++;
            end
        end
        tests++;
        if (npop != 5) fail_line("rr_pop_total", npop, 5);
        tests++;
        if (sent_count !== 8'd5) fail_line("rr_sent_count", int'(sent_count), 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
